// File: rtl/axi_lite_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regs_if
// Brief    : AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface axi_lite_regs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) ();
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_regs.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regs
// Brief    : Parametrised AXI4-Lite register bank: NUM_CTRL RW control words
//            followed by NUM_STAT RO status words, byte strobes, one-entry
//            AW/W holders, SLVERR on status writes, DECERR out of range.
//            Optional macro AXI_LITE_REGS_PROT_EN: unprivileged accesses
//            (prot[0]=0) to in-range registers are rejected with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CTRL   = 8,
  parameter int NUM_STAT   = 8,
  parameter logic [NUM_CTRL*DATA_WIDTH-1:0] CTRL_RESET = '0
) (
  input  logic                                            s_axi_aclk,
  input  logic                                            s_axi_areset,
  axi_lite_regs_if.slave                                  s_axi,
  output wire logic [NUM_CTRL*DATA_WIDTH-1:0]             ctrl,
  output logic [NUM_CTRL-1:0]                             ctrl_wr,
  input  logic [((NUM_STAT > 0) ? NUM_STAT : 1)*DATA_WIDTH-1:0] stat
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  // Decode compares run at a width that always holds NUM_CTRL+NUM_STAT (<=512).
  localparam int CMP_W    = (IDX_W > 10) ? IDX_W : 10;
  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam logic [1:0] C_RESP_DECERR = 2'b11;

  // Write holders
  logic                  r_aw_full;
  logic                  r_w_full;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [STRB_W-1:0]     r_w_strb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_commit;
  logic [CMP_W-1:0]      w_wr_cmp;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic                  w_wr_is_ctrl;
  logic                  w_wr_is_stat;
  logic                  w_wr_priv;
  logic                  w_wr_en;
  logic [NUM_CTRL-1:0]   w_wr_sel;
  logic [1:0]            w_wr_resp;
  logic                  w_arready;
  logic                  w_ar_hs;
  logic [CMP_W-1:0]      w_ar_cmp;
  logic                  w_rd_priv;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [1:0]            w_rresp;
  logic                  w_unused;

  assign s_axi.awready = !r_aw_full;
  assign s_axi.wready  = !r_w_full;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = w_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;

  assign w_aw_hs  = s_axi.awvalid && !r_aw_full;
  assign w_w_hs   = s_axi.wvalid && !r_w_full;
  // A beat arriving this cycle is used directly, so an empty holder never delays a commit.
  assign w_commit = (r_aw_full || s_axi.awvalid) && (r_w_full || s_axi.wvalid) &&
                    (!r_bvalid || s_axi.bready);

  assign w_wr_cmp  = CMP_W'(r_aw_full ? r_aw_idx : s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB]);
  assign w_wr_data = r_w_full ? r_w_data : s_axi.wdata;
  assign w_wr_strb = r_w_full ? r_w_strb : s_axi.wstrb;
  assign w_wr_is_ctrl = w_wr_cmp < CMP_W'(NUM_CTRL);
  assign w_wr_is_stat = !w_wr_is_ctrl && (w_wr_cmp < CMP_W'(NUM_CTRL + NUM_STAT));
  assign w_wr_en   = w_commit && w_wr_is_ctrl && w_wr_priv;

  assign w_arready = !r_rvalid || s_axi.rready;
  assign w_ar_hs   = s_axi.arvalid && w_arready;
  assign w_ar_cmp  = CMP_W'(s_axi.araddr[ADDR_WIDTH-1:ADDR_LSB]);

`ifdef AXI_LITE_REGS_PROT_EN
  logic r_aw_priv;

  // Capture the privilege bit alongside the held write address.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset)  r_aw_priv <= 1'b0;
    else if (w_aw_hs)  r_aw_priv <= s_axi.awprot[0];
  end

  assign w_wr_priv = r_aw_full ? r_aw_priv : s_axi.awprot[0];
  assign w_rd_priv = s_axi.arprot[0];
  assign w_unused  = ^{s_axi.awprot[2:1], s_axi.arprot[2:1], stat,
                       s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};
`else
  assign w_wr_priv = 1'b1;
  assign w_rd_priv = 1'b1;
  assign w_unused  = ^{s_axi.awprot, s_axi.arprot, stat,
                       s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};
`endif

  // AW/W holders: fill on handshake, free on commit.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_aw_full <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
    end else begin
      if (w_commit) begin
        r_aw_full <= 1'b0;
      end else if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= s_axi.awaddr[ADDR_WIDTH-1:ADDR_LSB];
      end
      if (w_commit) begin
        r_w_full <= 1'b0;
      end else if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= s_axi.wdata;
        r_w_strb <= s_axi.wstrb;
      end
    end
  end

  // Write decode: per-register select and response code.
  always_comb begin
    w_wr_sel = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      w_wr_sel[k] = w_wr_en && (w_wr_cmp == CMP_W'(k));
    end
    if (w_wr_is_ctrl)      w_wr_resp = w_wr_priv ? C_RESP_OKAY : C_RESP_SLVERR;
    else if (w_wr_is_stat) w_wr_resp = C_RESP_SLVERR;
    else                   w_wr_resp = C_RESP_DECERR;
  end

  generate
    for (genvar k = 0; k < NUM_CTRL; k++) begin : g_ctrl
      logic [DATA_WIDTH-1:0] r_word;

      // Control word with byte-strobed update.
      always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
          r_word <= CTRL_RESET[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (w_wr_sel[k]) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wr_strb[b]) r_word[b*8 +: 8] <= w_wr_data[b*8 +: 8];
          end
        end
      end

      assign ctrl[k*DATA_WIDTH +: DATA_WIDTH] = r_word;
    end
  endgenerate

  // Update pulse per control register, aligned with the new contents.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) ctrl_wr <= '0;
    else              ctrl_wr <= w_wr_sel;
  end

  // Write response channel.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_bvalid <= 1'b0;
      r_bresp  <= C_RESP_OKAY;
    end else if (w_commit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_wr_resp;
    end else if (s_axi.bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read mux; control reads see pre-write contents when a write commits in the same cycle.
  always_comb begin
    w_rdata = '0;
    w_rresp = C_RESP_DECERR;
    if (w_ar_cmp < CMP_W'(NUM_CTRL)) begin
      w_rresp = C_RESP_OKAY;
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (w_ar_cmp == CMP_W'(k)) w_rdata = ctrl[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (w_ar_cmp < CMP_W'(NUM_CTRL + NUM_STAT)) begin
      w_rresp = C_RESP_OKAY;
      for (int k = 0; k < NUM_STAT; k++) begin
        if (w_ar_cmp == CMP_W'(NUM_CTRL + k)) w_rdata = stat[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if ((w_rresp == C_RESP_OKAY) && !w_rd_priv) begin
      w_rdata = '0;
      w_rresp = C_RESP_SLVERR;
    end
  end

  // Read data channel: one-cycle latency, held while the master stalls.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= C_RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rdata;
      r_rresp  <= w_rresp;
    end else if (s_axi.rready) begin
      r_rvalid <= 1'b0;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_regs
// Brief    : Directed self-checking bench for axi_lite_regs (8 ctrl, 8 stat).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regs;
  localparam logic [255:0] C_CTRL_RESET = 256'hA5;

  logic         clk = 1'b0;
  logic         rst;
  wire  [255:0] ctrl;
  wire  [7:0]   ctrl_wr;
  logic [255:0] stat;
  int           n_checks = 0;
  int           n_fail   = 0;

  axi_lite_regs_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axi_lite_regs #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .NUM_CTRL   (8),
    .NUM_STAT   (8),
    .CTRL_RESET (C_CTRL_RESET)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .s_axi        (bus),
    .ctrl         (ctrl),
    .ctrl_wr      (ctrl_wr),
    .stat         (stat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                    input logic [2:0] prot, output logic [1:0] resp);
    int   t;
    logic aw_ok;
    logic w_ok;
    bus.bready  = 1'b1;
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.awprot  = prot;
    bus.wvalid  = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    t = 0;
    while (bus.awvalid || bus.wvalid) begin
      aw_ok = bus.awvalid && bus.awready;
      w_ok  = bus.wvalid && bus.wready;
      tick();
      if (aw_ok) bus.awvalid = 1'b0;
      if (w_ok)  bus.wvalid  = 1'b0;
      t++;
      if (t > 50) begin
        check("wr_accept_timeout", 64'(t), 64'd0);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
      end
    end
    t = 0;
    while (!bus.bvalid && t < 50) begin
      tick();
      t++;
    end
    check("wr_bvalid", 64'(bus.bvalid), 64'd1);
    resp = bus.bresp;
    tick();
  endtask

  task automatic rd(input logic [15:0] addr, input logic [2:0] prot,
                    output logic [31:0] data, output logic [1:0] resp);
    int t;
    bus.rready  = 1'b1;
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arprot  = prot;
    t = 0;
    while (!bus.arready && t < 50) begin
      tick();
      t++;
    end
    tick();
    bus.arvalid = 1'b0;
    check("rd_rvalid", 64'(bus.rvalid), 64'd1);
    data = bus.rdata;
    resp = bus.rresp;
    tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [1:0]  resp_seen [3];
    int          n_resp;
    int          t;
    logic        aw_ok, w_ok, b_ok;

    rst = 1'b1;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = 3'b001;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = 3'b001;
    bus.rready  = 1'b1;
    stat = '0;
    stat[31:0]      = 32'h0000_1234;
    stat[7*32 +: 32] = 32'hCAFE_0007;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_ctrl0",   64'(ctrl[31:0]), 64'hA5);
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_wready",  64'(bus.wready), 64'd1);
    check("rst_arready", 64'(bus.arready), 64'd1);
    check("rst_bvalid",  64'(bus.bvalid), 64'd0);
    check("rst_rvalid",  64'(bus.rvalid), 64'd0);
    check("rst_rdata",   64'(bus.rdata), 64'd0);
    check("rst_ctrl_wr", 64'(ctrl_wr), 64'd0);

    // Reset in the middle of write traffic
    bus.awvalid = 1'b1; bus.awaddr = 16'h0;
    bus.wvalid  = 1'b1; bus.wdata  = 32'h55; bus.wstrb = 4'hF;
    tick();
    bus.wvalid = 1'b0;
    bus.awaddr = 16'h4;
    check("mid_ctrl0_written", 64'(ctrl[31:0]), 64'h55);
    check("mid_bvalid",        64'(bus.bvalid), 64'd1);
    tick();
    bus.awvalid = 1'b0;
    check("mid_aw_held", 64'(bus.awready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("mrst_ctrl0",   64'(ctrl[31:0]), 64'hA5);
    check("mrst_bvalid",  64'(bus.bvalid), 64'd0);
    check("mrst_rvalid",  64'(bus.rvalid), 64'd0);
    check("mrst_awready", 64'(bus.awready), 64'd1);
    check("mrst_wready",  64'(bus.wready), 64'd1);
    check("mrst_arready", 64'(bus.arready), 64'd1);
    check("mrst_ctrl_wr", 64'(ctrl_wr), 64'd0);
    tick();
    rst = 1'b0;
    bus.bready = 1'b1;

    // Full-strobe write, AW one cycle ahead of W
    bus.awvalid = 1'b1; bus.awaddr = 16'h4; bus.awprot = 3'b001;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF;
    check("fs_ctrl_wr_idle", 64'(ctrl_wr), 64'd0);
    tick();
    bus.wvalid = 1'b0;
    check("fs_bvalid",        64'(bus.bvalid), 64'd1);
    check("fs_bresp",         64'(bus.bresp), 64'd0);
    check("fs_ctrl_wr_pulse", 64'(ctrl_wr), 64'h2);
    tick();
    check("fs_ctrl_wr_clear", 64'(ctrl_wr), 64'd0);
    check("fs_bvalid_clear",  64'(bus.bvalid), 64'd0);
    rd(16'h4, 3'b001, d, r);
    check("fs_rdata", 64'(d), 64'hDEAD_BEEF);
    check("fs_rresp", 64'(r), 64'd0);

    // Partial-strobe write
    wr(16'h4, 32'h1122_3344, 4'h5, 3'b001, r);
    check("ps_bresp", 64'(r), 64'd0);
    rd(16'h4, 3'b001, d, r);
    check("ps_rdata", 64'(d), 64'hDE22_BE44);

    // Status reads, decode errors, last-register boundaries
    rd(16'h20, 3'b001, d, r);
    check("st0_rdata", 64'(d), 64'h1234);
    check("st0_rresp", 64'(r), 64'd0);
    rd(16'h22, 3'b001, d, r);
    check("st0_lowbits_rdata", 64'(d), 64'h1234);
    rd(16'h3C, 3'b001, d, r);
    check("st7_rdata", 64'(d), 64'hCAFE_0007);
    check("st7_rresp", 64'(r), 64'd0);
    wr(16'h20, 32'hFFFF_FFFF, 4'hF, 3'b001, r);
    check("st_wr_bresp",   64'(r), 64'h2);
    check("st_wr_ctrl_lo", 64'(ctrl[63:0]), 64'hDE22_BE44_0000_00A5);
    check("st_wr_ctrl_hi", 64'(|ctrl[255:64]), 64'd0);
    rd(16'h40, 3'b001, d, r);
    check("oor_rdata", 64'(d), 64'd0);
    check("oor_rresp", 64'(r), 64'h3);
    wr(16'h40, 32'hFFFF_FFFF, 4'hF, 3'b001, r);
    check("oor_wr_bresp", 64'(r), 64'h3);
    check("oor_wr_ctrl_hi", 64'(|ctrl[255:64]), 64'd0);
    wr(16'h1C, 32'h1234_5678, 4'hF, 3'b001, r);
    check("c7_bresp", 64'(r), 64'd0);
    rd(16'h1C, 3'b001, d, r);
    check("c7_rdata", 64'(d), 64'h1234_5678);

    // Write backpressure: A commits, B held, C stalled
    bus.bready = 1'b0;
    bus.awvalid = 1'b1; bus.awaddr = 16'h8; bus.wvalid = 1'b1; bus.wdata = 32'h1; bus.wstrb = 4'hF;
    tick();
    check("bp_a_bvalid", 64'(bus.bvalid), 64'd1);
    check("bp_a_ctrl2",  64'(ctrl[95:64]), 64'h1);
    bus.awaddr = 16'h40; bus.wdata = 32'h2;
    tick();
    bus.awaddr = 16'hC; bus.wdata = 32'h3;
    check("bp_awready", 64'(bus.awready), 64'd0);
    check("bp_wready",  64'(bus.wready), 64'd0);
    check("bp_bresp_a", 64'(bus.bresp), 64'd0);
    tick();
    tick();
    check("bp_awready_hold", 64'(bus.awready), 64'd0);
    check("bp_ctrl3_idle",   64'(ctrl[127:96]), 64'd0);
    bus.bready = 1'b1;
    n_resp = 0;
    t = 0;
    for (int i = 0; i < 3; i++) resp_seen[i] = 2'b01;
    while (n_resp < 3 && t < 20) begin
      aw_ok = bus.awvalid && bus.awready;
      w_ok  = bus.wvalid && bus.wready;
      b_ok  = bus.bvalid && bus.bready;
      if (b_ok) begin
        resp_seen[n_resp] = bus.bresp;
        n_resp++;
      end
      tick();
      if (aw_ok) bus.awvalid = 1'b0;
      if (w_ok)  bus.wvalid  = 1'b0;
      t++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("bp_resp_count", 64'(n_resp), 64'd3);
    check("bp_resp0", 64'(resp_seen[0]), 64'h0);
    check("bp_resp1", 64'(resp_seen[1]), 64'h3);
    check("bp_resp2", 64'(resp_seen[2]), 64'h0);
    check("bp_ctrl2", 64'(ctrl[95:64]), 64'h1);
    check("bp_ctrl3", 64'(ctrl[127:96]), 64'h3);
    tick();
    check("bp_bvalid_done", 64'(bus.bvalid), 64'd0);

    // Read stall: data held, next AR waits
    bus.rready = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 16'h8; bus.arprot = 3'b001;
    tick();
    bus.araddr = 16'h4;
    for (int i = 0; i < 4; i++) begin
      check("rs_rvalid",  64'(bus.rvalid), 64'd1);
      check("rs_rdata",   64'(bus.rdata), 64'h1);
      check("rs_arready", 64'(bus.arready), 64'd0);
      tick();
    end
    check("rs_rdata_end", 64'(bus.rdata), 64'h1);
    bus.rready = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    check("rs_next_rvalid", 64'(bus.rvalid), 64'd1);
    check("rs_next_rdata",  64'(bus.rdata), 64'hDE22_BE44);
    tick();
    check("rs_rvalid_clear", 64'(bus.rvalid), 64'd0);

    // Read and write of the same register in the same cycle
    bus.awvalid = 1'b1; bus.awaddr = 16'hC;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'h99; bus.wstrb = 4'hF;
    bus.arvalid = 1'b1; bus.araddr = 16'hC;
    tick();
    bus.wvalid = 1'b0;
    bus.arvalid = 1'b0;
    check("sim_rdata_old", 64'(bus.rdata), 64'h3);
    check("sim_ctrl3_new", 64'(ctrl[127:96]), 64'h99);
    tick();
    rd(16'hC, 3'b001, d, r);
    check("sim_rdata_new", 64'(d), 64'h99);

`ifdef AXI_LITE_REGS_PROT_EN
    wr(16'h0, 32'h77, 4'hF, 3'b000, r);
    check("prot_wr_unpriv_bresp", 64'(r), 64'h2);
    check("prot_wr_unpriv_ctrl0", 64'(ctrl[31:0]), 64'hA5);
    wr(16'h0, 32'h77, 4'hF, 3'b001, r);
    check("prot_wr_priv_bresp", 64'(r), 64'h0);
    check("prot_wr_priv_ctrl0", 64'(ctrl[31:0]), 64'h77);
    rd(16'h0, 3'b000, d, r);
    check("prot_rd_unpriv_rdata", 64'(d), 64'h0);
    check("prot_rd_unpriv_rresp", 64'(r), 64'h2);
    rd(16'h40, 3'b000, d, r);
    check("prot_rd_oor_rresp", 64'(r), 64'h3);
`else
    wr(16'h0, 32'h77, 4'hF, 3'b000, r);
    check("noprot_wr_bresp", 64'(r), 64'h0);
    check("noprot_wr_ctrl0", 64'(ctrl[31:0]), 64'h77);
    rd(16'h0, 3'b000, d, r);
    check("noprot_rd_rdata", 64'(d), 64'h77);
    check("noprot_rd_rresp", 64'(r), 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axi_lite_regs.md
Name: axi_lite_regs

Overview:
Parametrised AXI4-Lite register bank. It generalises the fixed 16x32 control block to configurable data width, address width, and RW/RO register counts. It adds read-only hardware status registers, per-register write strobes, and SLVERR/DECERR responses. It sits between the PS AXI-Lite interconnect and wiphy datapath blocks: control fields fan out, and status fields fan in.

Parameters:
DATA_WIDTH, 32, bus and register width; 32 or 64 only.
ADDR_WIDTH, 16, AXI address width.
NUM_CTRL, 8, RW control registers at word indices 0..NUM_CTRL-1; 1..256.
NUM_STAT, 8, RO status registers at word indices NUM_CTRL..NUM_CTRL+NUM_STAT-1; 0..256.
CTRL_RESET, '0, NUM_CTRL*DATA_WIDTH flat vector of control reset values; register k is bits [k*DATA_WIDTH +: DATA_WIDTH].

Ports:
s_axi_aclk  in  1  clock
s_axi_areset  in  1  async active-high reset
s_axi_awvalid/awready  in/out  1  write address handshake
s_axi_awaddr  in  ADDR_WIDTH  byte address
s_axi_awprot  in  3  protection
s_axi_wvalid/wready  in/out  1  write data handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  byte strobes
s_axi_bvalid/bready  out/in  1  write response handshake
s_axi_bresp  out  2  write response
s_axi_arvalid/arready  in/out  1  read address handshake
s_axi_araddr  in  ADDR_WIDTH  byte address
s_axi_arprot  in  3  protection
s_axi_rvalid/rready  out/in  1  read data handshake
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
ctrl  out  NUM_CTRL*DATA_WIDTH  control register contents, flat
ctrl_wr  out  NUM_CTRL  one-cycle pulse per register on committed write
stat  in  max(NUM_STAT,1)*DATA_WIDTH  status inputs, flat, in s_axi_aclk domain

Behaviour:
- Clock and reset: one clock, s_axi_aclk. s_axi_areset is asynchronous and active-high. Every flop below resets asynchronously.
- Reset values: awready=wready=arready=1, bvalid=rvalid=0, bresp=rresp=0, rdata=0, ctrl=CTRL_RESET, ctrl_wr=0.
- Address decode: idx = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]; low bits are ignored.
  - idx < NUM_CTRL: RW control register.
  - idx < NUM_CTRL+NUM_STAT: RO status register.
  - Otherwise: DECERR (2'b11).
- Write channel:
  - AW and W each have a one-entry holding register. awready=1 iff the AW holder is empty; wready=1 iff the W holder is empty.
  - AW and W may arrive in either order or in the same cycle.
  - Commit occurs in the cycle where both holders are full (or being filled) and (!bvalid || bready).
  - On commit, both holders are freed and bvalid is set on the next edge.
- Write effect:
  - Control idx: bytes with wstrb set are updated; ctrl_wr[idx] pulses on the next cycle; bresp=OKAY.
  - Status idx: no state change; bresp=SLVERR (2'b10).
  - Out of range: no state change; bresp=DECERR.
- Write throughput and backpressure:
  - Back-to-back commits give one write per cycle when bready is held high.
  - While bvalid && !bready, at most one further AW and one further W are accepted into the holders, then ready deasserts.
- Read channel:
  - arready = !rvalid || rready (combinational).
  - On AR handshake, rdata/rresp are registered and rvalid=1 on the next edge (1-cycle latency).
  - rdata and rresp are held stable while rvalid && !rready.
- Read data:
  - Control idx returns ctrl[idx].
  - Status idx returns stat[idx-NUM_CTRL], sampled at the handshake edge.
  - Out of range returns 0 with DECERR.
- Simultaneous read and write: a read of a register whose write commits in the same cycle returns the old value.
- Reset mid-transaction: reset drops all held and outstanding beats; no response is issued; ctrl returns to CTRL_RESET.
- Unused inputs: awprot and arprot are ignored unless the optional feature is enabled.

Optional Feature:
AXI_LITE_REGS_PROT_EN.
- Defined: an access with prot[0]=0 (unprivileged) to any in-range register returns SLVERR. A rejected write changes no state and fires no ctrl_wr; a rejected read returns rdata=0. Out-of-range accesses still return DECERR.
- Undefined: awprot and arprot are ignored entirely.

Test Plan:
- Reset: assert s_axi_areset mid-write with CTRL_RESET word0=0x0000_00A5 -> ctrl word0=0xA5, bvalid=0, rvalid=0, awready=wready=arready=1.
- Full-strobe write: write 0xDEADBEEF to addr 0x4, wstrb=0xF, AW one cycle before W -> bresp=OKAY, ctrl_wr=0b10 for exactly one cycle, read of 0x4 returns 0xDEADBEEF with rresp=OKAY.
- Partial-strobe write: write 0x11223344 to addr 0x4 with wstrb=0x5 over 0xDEADBEEF -> readback 0xDE22BE44.
- Status and decode errors (NUM_CTRL=8, NUM_STAT=8):
  - Read addr 0x20 with stat word0=0x1234 -> 0x1234, OKAY.
  - Write addr 0x20 -> SLVERR, no ctrl change.
  - Read addr 0x40 -> rdata=0, DECERR.
- Backpressure:
  - Hold bready=0 and issue 3 writes -> one response pending, one AW/W pair held, awready=wready=0.
  - Release bready -> responses arrive in order and all three writes commit.
  - Read with rready=0 for 4 cycles -> rdata stable, arready=0.
- AXI_LITE_REGS_PROT_EN defined: write addr 0x0 with awprot=3'b000 -> SLVERR, ctrl word0 unchanged; the same write with awprot=3'b001 -> OKAY.
